axis_stream_rr_arbiter: RTL and testbench

- Packet-granular round-robin arbiter that shares one 32-bit AXI-stream master port between NUM_SRC stream sources.
- Typical sources: the FIFO-to-stream packer outputs. The sink is the PCIe-side stream consumer.
- Once a source is granted, it holds the output until its tlast beat is accepted, so packets never interleave.
- A one-stage output register keeps tvalid and tdata off the combinational path to the sink.

---
 rtl/axis_arb_pkg.sv | 31 +++
 rtl/axis_out_reg.sv | 42 ++++
 rtl/axis_stream_rr_arbiter.sv | 150 +++++++++++++++
 tb/tb_axis_stream_rr_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_arb_pkg.sv
// rtl/axis_arb_pkg.sv - shared types, constants and round-robin pick helper for the stream arbiter
package axis_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    localparam int AXIS_DATA_W = 32;
    localparam int AXIS_STRB_W = 4;

    // Returns {found, index}: first set request searching last+1, last+2, ... modulo num.
    // Requests are zero-extended to 8 bits so one helper serves every source count.
    function automatic logic [3:0] rr_pick(input logic [7:0] req,
                                           input logic [2:0] last,
                                           input int         num);
        logic [3:0] res;
        int         cand;
        res = '0;
        for (int k = 1; k <= 8; k++) begin
            if (k <= num && !res[3]) begin
                cand = (int'(last) + k) % num;
                if (req[3'(cand)]) begin
                    res = {1'b1, 3'(cand)};
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// rtl/axis_out_reg.sv - single-stage AXI-stream output register with slot_free back-pressure
module axis_out_reg
    import axis_arb_pkg::*;
#(
    parameter int DATA_W = AXIS_DATA_W,
    parameter int STRB_W = AXIS_STRB_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [STRB_W-1:0] in_strb,
    input  logic              in_last,
    output logic              slot_free,
    output logic [DATA_W-1:0] m00_axis_tdata,
    output logic [STRB_W-1:0] m00_axis_tstrb,
    output logic              m00_axis_tlast,
    output logic              m00_axis_tvalid,
    input  logic              m00_axis_tready
);

    // The slot can take a new beat when empty or when its current beat leaves this cycle.
    assign slot_free = !m00_axis_tvalid || m00_axis_tready;

    // Load a new beat, or retire the held one; payload only changes on a load so it stays stable while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m00_axis_tvalid <= 1'b0;
            m00_axis_tdata  <= '0;
            m00_axis_tstrb  <= '0;
            m00_axis_tlast  <= 1'b0;
        end else if (in_valid) begin
            m00_axis_tvalid <= 1'b1;
            m00_axis_tdata  <= in_data;
            m00_axis_tstrb  <= in_strb;
            m00_axis_tlast  <= in_last;
        end else if (m00_axis_tvalid && m00_axis_tready) begin
            m00_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_stream_rr_arbiter.sv
// rtl/axis_stream_rr_arbiter.sv - packet-granular round-robin arbiter of NUM_SRC streams onto one master port
module axis_stream_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int DATA_W    = AXIS_DATA_W,
    parameter int MAX_BEATS = 1024
) (
    input  logic                        m00_axis_aclk,
    input  logic                        m00_axis_aresetn,
    input  logic [NUM_SRC*DATA_W-1:0]   s_axis_tdata,
    input  logic [NUM_SRC*DATA_W/8-1:0] s_axis_tstrb,
    input  logic [NUM_SRC-1:0]          s_axis_tlast,
    input  logic [NUM_SRC-1:0]          s_axis_tvalid,
    output logic [NUM_SRC-1:0]          s_axis_tready,
    output logic [DATA_W-1:0]           m00_axis_tdata,
    output logic [DATA_W/8-1:0]         m00_axis_tstrb,
    output logic                        m00_axis_tlast,
    output logic                        m00_axis_tvalid,
    input  logic                        m00_axis_tready,
    output logic [2:0]                  grant_id,
    output logic                        busy,
    output logic [15:0]                 pkt_cnt,
    output logic                        ovf_err
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(MAX_BEATS + 1);
    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_BEATS);
    localparam logic [CNT_W-1:0] MAX_M1 = CNT_W'(MAX_BEATS - 1);

    arb_state_t       state, state_nxt;
    logic [2:0]       last_grant, last_grant_nxt;
    logic [2:0]       grant_q, grant_nxt;
    logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
    logic [15:0]      pkt_cnt_q, pkt_cnt_nxt;
    logic             ovf_q, ovf_nxt;

    logic [7:0]        req_ext;
    logic [3:0]        pick;
    logic              slot_free;
    logic              accept;
    logic              sel_valid;
    logic              sel_last;
    logic [DATA_W-1:0] sel_data;
    logic [STRB_W-1:0] sel_strb;

    // Arbiter state register; reset leaves last_grant at the top index so source 0 wins first.
    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            state      <= IDLE;
            last_grant <= 3'(NUM_SRC - 1);
            grant_q    <= 3'd0;
            beat_cnt   <= '0;
            pkt_cnt_q  <= 16'd0;
            ovf_q      <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            grant_q    <= grant_nxt;
            beat_cnt   <= beat_cnt_nxt;
            pkt_cnt_q  <= pkt_cnt_nxt;
            ovf_q      <= ovf_nxt;
        end
    end

    // Next-state, source select and ready generation; the granted source is locked until its tlast beat.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        grant_nxt      = grant_q;
        beat_cnt_nxt   = beat_cnt;
        pkt_cnt_nxt    = pkt_cnt_q;
        ovf_nxt        = ovf_q;
        s_axis_tready  = '0;
        accept         = 1'b0;
        sel_valid      = 1'b0;
        sel_last       = 1'b0;
        sel_data       = '0;
        sel_strb       = '0;

        req_ext                = '0;
        req_ext[NUM_SRC-1:0]   = s_axis_tvalid;
        pick                   = rr_pick(req_ext, last_grant, NUM_SRC);

        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_q == 3'(i)) begin
                sel_valid = s_axis_tvalid[i];
                sel_last  = s_axis_tlast[i];
                sel_data  = s_axis_tdata[i*DATA_W +: DATA_W];
                sel_strb  = s_axis_tstrb[i*STRB_W +: STRB_W];
            end
        end

        case (state)
            IDLE: begin
                if (pick[3]) begin
                    grant_nxt      = pick[2:0];
                    last_grant_nxt = pick[2:0];
                    state_nxt      = XFER;
                end
            end
            XFER: begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    s_axis_tready[i] = slot_free && (grant_q == 3'(i));
                end
                accept = sel_valid && slot_free;
                if (accept) begin
                    if (sel_last) begin
                        state_nxt    = IDLE;
                        beat_cnt_nxt = '0;
                        pkt_cnt_nxt  = pkt_cnt_q + 16'd1;
                    end else begin
                        if (beat_cnt < MAX_C) begin
                            beat_cnt_nxt = beat_cnt + 1'b1;
                        end
                        if (beat_cnt >= MAX_M1) begin
                            ovf_nxt = 1'b1;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    axis_out_reg #(
        .DATA_W (DATA_W),
        .STRB_W (STRB_W)
    ) u_out_reg (
        .clk             (m00_axis_aclk),
        .rst_n           (m00_axis_aresetn),
        .in_valid        (accept),
        .in_data         (sel_data),
        .in_strb         (sel_strb),
        .in_last         (sel_last),
        .slot_free       (slot_free),
        .m00_axis_tdata  (m00_axis_tdata),
        .m00_axis_tstrb  (m00_axis_tstrb),
        .m00_axis_tlast  (m00_axis_tlast),
        .m00_axis_tvalid (m00_axis_tvalid),
        .m00_axis_tready (m00_axis_tready)
    );

    assign grant_id = grant_q;
    assign busy     = (state == XFER);
    assign pkt_cnt  = pkt_cnt_q;
    assign ovf_err  = ovf_q;

endmodule

// File: tb/tb_axis_stream_rr_arbiter.sv
// tb/tb_axis_stream_rr_arbiter.sv - directed scoreboard bench for the round-robin stream arbiter
module tb_axis_stream_rr_arbiter;

    localparam int NS = 4;
    localparam int DW = 32;
    localparam int SW = 4;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NS*DW-1:0] s_tdata;
    logic [NS*SW-1:0] s_tstrb;
    logic [NS-1:0]    s_tlast;
    logic [NS-1:0]    s_tvalid;
    logic [NS-1:0]    s_tready;
    logic [DW-1:0]    m_tdata;
    logic [SW-1:0]    m_tstrb;
    logic             m_tlast;
    logic             m_tvalid;
    logic             m_tready;
    logic [2:0]       grant_id;
    logic             busy;
    logic [15:0]      pkt_cnt;
    logic             ovf_err;

    axis_stream_rr_arbiter #(
        .NUM_SRC   (NS),
        .DATA_W    (DW),
        .MAX_BEATS (8)
    ) dut (
        .m00_axis_aclk    (clk),
        .m00_axis_aresetn (rst_n),
        .s_axis_tdata     (s_tdata),
        .s_axis_tstrb     (s_tstrb),
        .s_axis_tlast     (s_tlast),
        .s_axis_tvalid    (s_tvalid),
        .s_axis_tready    (s_tready),
        .m00_axis_tdata   (m_tdata),
        .m00_axis_tstrb   (m_tstrb),
        .m00_axis_tlast   (m_tlast),
        .m00_axis_tvalid  (m_tvalid),
        .m00_axis_tready  (m_tready),
        .grant_id         (grant_id),
        .busy             (busy),
        .pkt_cnt          (pkt_cnt),
        .ovf_err          (ovf_err)
    );

    always #5 clk = ~clk;

    beat_t      src_q[NS][$];
    beat_t      exp_q[$];
    logic [3:0] src_en;
    int         out_cycles[$];
    int         acc_cnt[NS];
    int         out_beats;
    int         cyc;
    int         checks;
    int         passes;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) passes++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    endtask

    task automatic drive();
        for (int i = 0; i < NS; i++) begin
            if (src_en[i] && src_q[i].size() > 0) begin
                s_tvalid[i]          = 1'b1;
                s_tdata[i*DW +: DW]  = src_q[i][0].data;
                s_tstrb[i*SW +: SW]  = src_q[i][0].strb;
                s_tlast[i]           = src_q[i][0].last;
            end else begin
                s_tvalid[i]          = 1'b0;
                s_tdata[i*DW +: DW]  = '0;
                s_tstrb[i*SW +: SW]  = '0;
                s_tlast[i]           = 1'b0;
            end
        end
    endtask

    task automatic add_pkt(input int src, input int n, input logic [31:0] base);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.data = base + 32'(k);
            b.last = (k == n - 1);
            b.strb = b.last ? 4'h3 : 4'hF;
            src_q[src].push_back(b);
            exp_q.push_back(b);
        end
    endtask

    task automatic step();
        logic [3:0] acc;
        logic       macc;
        beat_t      e;
        @(negedge clk);
        acc  = s_tvalid & s_tready;
        macc = m_tvalid & m_tready;
        chk("tready_onehot", 32'($countones(s_tready) <= 1), 32'd1);
        if (macc) begin
            out_beats++;
            out_cycles.push_back(cyc);
            chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("out_tdata", m_tdata, e.data);
                chk("out_tstrb", 32'(m_tstrb), 32'(e.strb));
                chk("out_tlast", 32'(m_tlast), 32'(e.last));
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NS; i++) begin
            if (acc[i]) begin
                void'(src_q[i].pop_front());
                acc_cnt[i]++;
            end
        end
        drive();
    endtask

    task automatic wait_drain(input int max_cyc);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy || m_tvalid) && n < max_cyc) begin
            step();
            n++;
        end
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic flush();
        exp_q.delete();
        for (int i = 0; i < NS; i++) src_q[i].delete();
        drive();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        flush();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int a0;
        logic [31:0] held_data;
        logic        held_last;

        checks = 0; passes = 0; cyc = 0; out_beats = 0;
        for (int i = 0; i < NS; i++) acc_cnt[i] = 0;
        rst_n = 1'b0; m_tready = 1'b1; src_en = 4'hF;
        s_tdata = '0; s_tstrb = '0; s_tlast = '0; s_tvalid = '0;
        repeat (3) @(posedge clk);
        #1;

        // reset state
        chk("rst_tvalid",   32'(m_tvalid), 32'd0);
        chk("rst_tdata",    m_tdata, 32'd0);
        chk("rst_tlast",    32'(m_tlast), 32'd0);
        chk("rst_tready",   32'(s_tready), 32'd0);
        chk("rst_busy",     32'(busy), 32'd0);
        chk("rst_grant",    32'(grant_id), 32'd0);
        chk("rst_pkt_cnt",  32'(pkt_cnt), 32'd0);
        chk("rst_ovf",      32'(ovf_err), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single source, 3 beats, latency check
        add_pkt(2, 3, 32'hA0);
        drive();
        step();
        chk("t1_tready_c1", 32'(s_tready), 32'h4);
        chk("t1_tvalid_c1", 32'(m_tvalid), 32'd0);
        chk("t1_grant_c1",  32'(grant_id), 32'd2);
        step();
        chk("t1_tvalid_c2", 32'(m_tvalid), 32'd1);
        chk("t1_tdata_c2",  m_tdata, 32'hA0);
        wait_drain(30);
        chk("t1_pkt_cnt", 32'(pkt_cnt), 32'd1);
        chk("t1_grant",   32'(grant_id), 32'd2);

        // three contending sources: order 0,1,3 with one idle cycle between packets
        do_reset();
        out_cycles.delete();
        add_pkt(0, 2, 32'h100);
        add_pkt(1, 2, 32'h110);
        add_pkt(3, 2, 32'h130);
        drive();
        wait_drain(60);
        chk("t2_nbeats", 32'(out_cycles.size()), 32'd6);
        if (out_cycles.size() == 6) begin
            chk("t2_gap01", 32'(out_cycles[1] - out_cycles[0]), 32'd1);
            chk("t2_gap12", 32'(out_cycles[2] - out_cycles[1]), 32'd2);
            chk("t2_gap23", 32'(out_cycles[3] - out_cycles[2]), 32'd1);
            chk("t2_gap34", 32'(out_cycles[4] - out_cycles[3]), 32'd2);
            chk("t2_gap45", 32'(out_cycles[5] - out_cycles[4]), 32'd1);
        end
        add_pkt(0, 1, 32'h140);
        drive();
        step();
        chk("t2_regrant0", 32'(grant_id), 32'd0);
        chk("t2_busy_1b",  32'(busy), 32'd1);
        step();
        chk("t2_idle_1b",  32'(busy), 32'd0);
        wait_drain(30);
        chk("t2_pkt_cnt", 32'(pkt_cnt), 32'd4);

        // sink stall mid-packet
        a0 = out_beats;
        add_pkt(0, 6, 32'h200);
        drive();
        n = 0;
        while (out_beats - a0 < 2 && n < 20) begin
            step();
            n++;
        end
        chk("t3_reach_stall", 32'(out_beats - a0), 32'd2);
        m_tready = 1'b0;
        #1;
        held_data = m_tdata;
        held_last = m_tlast;
        repeat (5) begin
            step();
            chk("t3_hold_valid",  32'(m_tvalid), 32'd1);
            chk("t3_hold_data",   m_tdata, held_data);
            chk("t3_hold_last",   32'(m_tlast), 32'(held_last));
            chk("t3_hold_tready", 32'(s_tready), 32'd0);
        end
        m_tready = 1'b1;
        wait_drain(40);
        chk("t3_total_beats", 32'(out_beats - a0), 32'd6);
        chk("t3_pkt_cnt", 32'(pkt_cnt), 32'd5);

        // granted source pauses while another source requests
        add_pkt(2, 5, 32'h300);
        drive();
        repeat (3) step();
        src_en[2] = 1'b0;
        add_pkt(1, 2, 32'h310);
        drive();
        repeat (3) begin
            step();
            chk("t4_grant_hold", 32'(grant_id), 32'd2);
            chk("t4_no_tready1", 32'(s_tready[1]), 32'd0);
            chk("t4_busy",       32'(busy), 32'd1);
        end
        src_en[2] = 1'b1;
        drive();
        wait_drain(40);
        chk("t4_grant_next", 32'(grant_id), 32'd1);
        chk("t4_pkt_cnt", 32'(pkt_cnt), 32'd7);

        // overflow on a 10-beat packet with an 8-beat limit
        chk("t5_ovf_pre", 32'(ovf_err), 32'd0);
        a0 = acc_cnt[3];
        add_pkt(3, 10, 32'h400);
        drive();
        n = 0;
        while (acc_cnt[3] - a0 < 10 && n < 60) begin
            step();
            n++;
            if (acc_cnt[3] - a0 <= 7) chk("t5_ovf_low", 32'(ovf_err), 32'd0);
            else if (acc_cnt[3] - a0 >= 9) chk("t5_ovf_high", 32'(ovf_err), 32'd1);
        end
        wait_drain(40);
        chk("t5_ovf_set", 32'(ovf_err), 32'd1);
        chk("t5_pkt_cnt", 32'(pkt_cnt), 32'd8);
        add_pkt(0, 2, 32'h410);
        drive();
        wait_drain(30);
        chk("t5_ovf_sticky", 32'(ovf_err), 32'd1);
        chk("t5_pkt_cnt2", 32'(pkt_cnt), 32'd9);

        // reset during beat 2 of a packet
        a0 = acc_cnt[1];
        add_pkt(1, 4, 32'h500);
        drive();
        n = 0;
        while (acc_cnt[1] - a0 < 2 && n < 20) begin
            step();
            n++;
        end
        rst_n = 1'b0;
        #1;
        chk("t6_tvalid", 32'(m_tvalid), 32'd0);
        chk("t6_tdata",  m_tdata, 32'd0);
        chk("t6_tlast",  32'(m_tlast), 32'd0);
        chk("t6_tready", 32'(s_tready), 32'd0);
        chk("t6_busy",   32'(busy), 32'd0);
        chk("t6_grant",  32'(grant_id), 32'd0);
        chk("t6_pkt",    32'(pkt_cnt), 32'd0);
        chk("t6_ovf",    32'(ovf_err), 32'd0);
        flush();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        add_pkt(0, 1, 32'h600);
        add_pkt(1, 1, 32'h610);
        drive();
        step();
        chk("t6_tie_grant0", 32'(grant_id), 32'd0);
        wait_drain(30);
        chk("t6_pkt_after", 32'(pkt_cnt), 32'd2);
        chk("t6_grant_last", 32'(grant_id), 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
